// File: rtl/skid_buffer_pkg.sv
// Shared types for the skid buffer: the control state encoding doubles as the
// word count presented on count_o.
package skid_buffer_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/skid_buffer_ctrl.sv
// Skid buffer control: occupancy state machine plus registered ready/valid
// flags and the load enables for the main and skid data registers.
module skid_buffer_ctrl
  import skid_buffer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        s_valid_i,
  input  logic        m_ready_i,
  output logic        s_ready_o,
  output logic        m_valid_o,
  output logic        main_load,
  output logic        main_sel_skid,
  output logic        skid_load,
  output skid_state_e state
);

  skid_state_e state_q;
  skid_state_e state_d;
  logic        s_ready_q;
  logic        m_valid_q;
  logic        s_fire;
  logic        m_fire;

  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    s_fire        = s_valid_i & s_ready_q;
    m_fire        = m_valid_q & m_ready_i;
    case (state_q)
      EMPTY: begin
        if (s_fire) begin
          state_d   = BUSY;
          main_load = 1'b1;
        end
      end
      BUSY: begin
        if (s_fire && m_fire) begin
          main_load = 1'b1;
        end else if (s_fire) begin
          state_d   = FULL;
          skid_load = 1'b1;
        end else if (m_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (m_fire) begin
          state_d       = BUSY;
          main_load     = 1'b1;
          main_sel_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over everything; suppressing the loads keeps a dropped word
    // from ever reaching the data registers.
    if (flush_i) begin
      state_d       = EMPTY;
      main_load     = 1'b0;
      main_sel_skid = 1'b0;
      skid_load     = 1'b0;
    end
  end

  // Ready/valid get their own flops so neither output has logic behind it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= EMPTY;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d != FULL);
      m_valid_q <= (state_d != EMPTY);
    end
  end

  assign s_ready_o = s_ready_q;
  assign m_valid_o = m_valid_q;
  assign state     = state_q;

  a_s_valid_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown(s_valid_i));
  a_m_ready_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown(m_ready_i));

endmodule

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice: main register feeds the consumer
// directly, skid register catches the word accepted while the consumer stalls.
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int                    WORD_WIDTH  = 8,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [WORD_WIDTH-1:0] s_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [WORD_WIDTH-1:0] m_data_o,
  output logic [1:0]            count_o
);

  logic                  main_load;
  logic                  main_sel_skid;
  logic                  skid_load;
  skid_state_e           state;
  logic [WORD_WIDTH-1:0] main_q;
  logic [WORD_WIDTH-1:0] skid_q;
  logic [WORD_WIDTH-1:0] main_d;

  skid_buffer_ctrl u_ctrl (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .s_valid_i     (s_valid_i),
    .m_ready_i     (m_ready_i),
    .s_ready_o     (s_ready_o),
    .m_valid_o     (m_valid_o),
    .main_load     (main_load),
    .main_sel_skid (main_sel_skid),
    .skid_load     (skid_load),
    .state         (state)
  );

  assign main_d = main_sel_skid ? skid_q : s_data_i;

  // Data registers only move on their enables, never on idle cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else begin
      if (main_load) main_q <= main_d;
      if (skid_load) skid_q <= s_data_i;
    end
  end

  assign m_data_o = main_q;
  assign count_o  = 2'(state);

endmodule
